// File: rtl/in_service_acknowledge_control_pkg.sv
// in_service_acknowledge_control_pkg: shared FSM states, call opcode and rotate/one-hot helpers.
// The WAIT3/ACK3 states exist only with CALL_MODE_8080_EN.
package in_service_acknowledge_control_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ACK1, S_WAIT2, S_ACK2
`ifdef CALL_MODE_8080_EN
    , S_WAIT3, S_ACK3
`endif
  } state_t;
  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] n);
    return (v << n) | (v >> (4'd8 - {1'b0, n}));
  endfunction
  function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] n);
    return (v >> n) | (v << (4'd8 - {1'b0, n}));
  endfunction
  function automatic logic [2:0] onehot_to_num(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/in_service_acknowledge_control_priority_resolver.sv
// priority_resolver: one-hot of the highest-ranked set bit under rotated priority.
module priority_resolver
  import in_service_acknowledge_control_pkg::*;
(
  input  logic [2:0] priority_rotate,
  input  logic [7:0] request,
  output logic [7:0] highest
);
  logic [2:0] sh;
  logic [7:0] rotated, first;
  always_comb begin
    sh = priority_rotate + 3'd1;
    rotated = rotr(request, sh);
    first = rotated & (~rotated + 8'd1);
    highest = rotl(first, sh);
  end
endmodule

// File: rtl/in_service_acknowledge_control.sv
// in_service_acknowledge_control: 8259A ISR and INTA# sequencer; CALL_MODE_8080_EN adds the 8080 three-byte CALL sequence.
module in_service_acknowledge_control
  import in_service_acknowledge_control_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_acknowledge_n,
  input  logic       write_initial_command_word_1,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] end_of_interrupt,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt_vector_high,
  output logic       interrupt,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] acknowledge_interrupt,
  output logic       end_of_acknowledge_sequence,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable
`ifdef CALL_MODE_8080_EN
  , input logic       mode_8086,
  input  logic [2:0] call_address_low
`endif
);
  state_t state_q, state_d;
  logic [7:0] isr_q, isr_d, ack_q, ack_d, dbo_q, dbo_d, req_hi, isr_hi, set_bit, ack2_byte;
  logic int_q, int_d, eoa_q, eoa_d, en_q, en_d, prev_q, prev_d;
  logic fall, rise, eligible, mode;
  logic [2:0] lvl, req_rank, isr_rank;
  priority_resolver u_req (.priority_rotate(priority_rotate), .request(interrupt_request), .highest(req_hi));
  priority_resolver u_isr (.priority_rotate(priority_rotate), .request(isr_q), .highest(isr_hi));
`ifdef CALL_MODE_8080_EN
  assign mode = mode_8086;
  assign ack2_byte = mode_8086 ? {interrupt_vector_high[7:3], lvl} : {call_address_low, lvl, 2'b00};
`else
  assign mode = 1'b1;
  assign ack2_byte = {interrupt_vector_high[7:3], lvl};
`endif
  always_comb begin
    fall = prev_q & ~interrupt_acknowledge_n;
    rise = ~prev_q & interrupt_acknowledge_n;
    lvl = onehot_to_num(ack_q);
    req_rank = onehot_to_num(req_hi) - priority_rotate - 3'd1;
    isr_rank = onehot_to_num(isr_hi) - priority_rotate - 3'd1;
    eligible = |req_hi && (~|isr_hi || req_rank < isr_rank);
    state_d = state_q;
    ack_d = ack_q;
    set_bit = '0;
    dbo_d = dbo_q;
    en_d = en_q;
    eoa_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        ack_d = '0;
        if (fall) begin
          state_d = S_ACK1;
          ack_d = eligible ? req_hi : 8'h80;
          set_bit = eligible ? req_hi : 8'h00;
          dbo_d = mode ? 8'h00 : CALL_OPCODE;
          en_d = ~mode;
        end
      end
      S_ACK1: if (rise) begin
        state_d = S_WAIT2;
        dbo_d = '0;
        en_d = 1'b0;
      end
      S_WAIT2: if (fall) begin
        state_d = S_ACK2;
        dbo_d = ack2_byte;
        en_d = 1'b1;
      end
      S_ACK2: if (rise) begin
        state_d = mode ? S_IDLE : state_t'(S_ACK2 + 3'd1);
        eoa_d = mode;
        dbo_d = '0;
        en_d = 1'b0;
      end
`ifdef CALL_MODE_8080_EN
      S_WAIT3: if (fall) begin
        state_d = S_ACK3;
        dbo_d = interrupt_vector_high;
        en_d = 1'b1;
      end
      S_ACK3: if (rise) begin
        state_d = S_IDLE;
        eoa_d = 1'b1;
        dbo_d = '0;
        en_d = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    isr_d = (isr_q & ~end_of_interrupt) | set_bit;
    int_d = eligible && state_d == S_IDLE;
    prev_d = interrupt_acknowledge_n;
    // Clearing prev makes an INTA# already low at soft reset wait for its rise.
    if (write_initial_command_word_1) begin
      state_d = S_IDLE;
      isr_d = '0;
      ack_d = '0;
      dbo_d = '0;
      en_d = 1'b0;
      eoa_d = 1'b0;
      int_d = 1'b0;
      prev_d = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      isr_q <= '0;
      ack_q <= '0;
      dbo_q <= '0;
      en_q <= 1'b0;
      eoa_q <= 1'b0;
      int_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      isr_q <= isr_d;
      ack_q <= ack_d;
      dbo_q <= dbo_d;
      en_q <= en_d;
      eoa_q <= eoa_d;
      int_q <= int_d;
      prev_q <= prev_d;
    end
  assign interrupt = int_q;
  assign in_service_register = isr_q;
  assign highest_level_in_service = isr_hi;
  assign acknowledge_interrupt = ack_q;
  assign end_of_acknowledge_sequence = eoa_q;
  assign data_bus_out = dbo_q;
  assign data_bus_out_enable = en_q;
endmodule

// File: tb/tb_in_service_acknowledge_control.sv
// tb_in_service_acknowledge_control: random and directed INTA# sequences checked against a rank-scanning ISR model.
module tb_in_service_acknowledge_control;
  logic clock = 0, reset_n = 0, interrupt_acknowledge_n = 1, write_initial_command_word_1 = 0;
  logic [7:0] interrupt_request = 0, end_of_interrupt = 0, interrupt_vector_high = 0;
  logic [2:0] priority_rotate = 0;
  logic interrupt, eoa, dbo_en;
  logic [7:0] isr, hls, ack, dbo;
  logic [7:0] m_isr = 0;
  int n_vec = 0, n_bad = 0;
`ifdef CALL_MODE_8080_EN
  logic mode_8086 = 1;
  logic [2:0] call_address_low = 0;
`endif
  always #5 clock = ~clock;
  in_service_acknowledge_control dut (
    .clock(clock), .reset_n(reset_n), .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .write_initial_command_word_1(write_initial_command_word_1), .interrupt_request(interrupt_request),
    .end_of_interrupt(end_of_interrupt), .priority_rotate(priority_rotate),
    .interrupt_vector_high(interrupt_vector_high), .interrupt(interrupt), .in_service_register(isr),
    .highest_level_in_service(hls), .acknowledge_interrupt(ack), .end_of_acknowledge_sequence(eoa),
    .data_bus_out(dbo), .data_bus_out_enable(dbo_en)
`ifdef CALL_MODE_8080_EN
    , .mode_8086(mode_8086), .call_address_low(call_address_low)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  // Walk levels from highest rank down; an in-service level blocks everything below it.
  function automatic int pick(input logic [7:0] req, input logic [7:0] is, input logic [2:0] pr);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (r + int'(pr) + 1) % 8;
      if (is[l]) return -1;
      if (req[l]) return l;
    end
    return -1;
  endfunction
  function automatic logic [7:0] top_isr(input logic [7:0] is, input logic [2:0] pr);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (r + int'(pr) + 1) % 8;
      if (is[l]) return 8'(1 << l);
    end
    return 8'h00;
  endfunction
  task automatic check_idle(input string tag);
    chk({tag, "_int"}, interrupt, pick(interrupt_request, m_isr, priority_rotate) >= 0);
    chk({tag, "_isr"}, isr, m_isr);
    chk({tag, "_hls"}, hls, top_isr(m_isr, priority_rotate));
    chk({tag, "_bus"}, {dbo_en, dbo}, 0);
  endtask
  task automatic apply_eoi(input logic [7:0] e);
    end_of_interrupt = e;
    tick();
    end_of_interrupt = 0;
    m_isr &= ~e;
    tick();
  endtask
  task automatic sequence_8086(input bit icw1_mid);
    int lvl;
    logic [7:0] b;
    logic [2:0] l3;
    lvl = pick(interrupt_request, m_isr, priority_rotate);
    b = lvl < 0 ? 8'h80 : 8'(1 << lvl);
    l3 = lvl < 0 ? 3'd7 : 3'(lvl);
    interrupt_acknowledge_n = 0;
    tick();
    if (lvl >= 0) m_isr |= b;
    chk("ack1_ack", ack, b);
    chk("ack1_isr", isr, m_isr);
    chk("ack1_int", interrupt, 0);
    chk("ack1_bus", {dbo_en, dbo}, 0);
    tick($urandom_range(0, 2));
    interrupt_acknowledge_n = 1;
    tick();
    chk("wait2_bus", dbo_en, 0);
    tick($urandom_range(0, 2));
    interrupt_acknowledge_n = 0;
    tick();
    chk("ack2_bus", {dbo_en, dbo}, {1'b1, interrupt_vector_high[7:3], l3});
    if (icw1_mid) begin
      write_initial_command_word_1 = 1;
      tick();
      write_initial_command_word_1 = 0;
      m_isr = 0;
      chk("icw1_bus", {dbo_en, dbo}, 0);
      chk("icw1_isr", isr, 0);
      chk("icw1_ack", ack, 0);
      tick(2);
      chk("icw1_hold_ack", {ack, dbo_en}, 0);
      interrupt_acknowledge_n = 1;
      tick();
      chk("icw1_no_eoa", eoa, 0);
      tick();
      chk("icw1_after", {eoa, ack, dbo_en}, 0);
      return;
    end
    tick($urandom_range(0, 2));
    interrupt_acknowledge_n = 1;
    tick();
    chk("eoa_pulse", {eoa, ack}, {1'b1, b});
    chk("eoa_bus", dbo_en, 0);
    chk("eoa_int", interrupt, pick(interrupt_request, m_isr, priority_rotate) >= 0);
    tick();
    chk("eoa_end", {eoa, ack}, 0);
  endtask
  initial begin
    tick(2);
    chk("rst_out", {interrupt, eoa, dbo_en, isr, ack, dbo}, 0);
    chk("rst_hls", hls, 0);
    reset_n = 1;
    tick(2);
    priority_rotate = 7;
    interrupt_vector_high = 8'h40;
    interrupt_request = 8'h0C;
    tick();
    chk("t1_int", interrupt, 1);
    sequence_8086(0);
    chk("t1_isr", isr, 8'h04);
    apply_eoi(8'hFF);
    interrupt_request = 8'h02;
    tick(2);
    sequence_8086(0);
    interrupt_request = 8'h08;
    tick(2);
    chk("t2_isr", isr, 8'h02);
    chk("t2_int_blocked", interrupt, 0);
    apply_eoi(8'h02);
    chk("t2_isr_clr", isr, 0);
    chk("t2_int_up", interrupt, 1);
    apply_eoi(8'hFF);
    priority_rotate = 3;
    interrupt_request = 8'h11;
    tick(2);
    sequence_8086(0);
    chk("t3_isr", isr, 8'h10);
    chk("t3_hls", hls, 8'h10);
    interrupt_request = 8'h00;
    tick(2);
    sequence_8086(0);
    chk("t4_spurious_isr", isr, 8'h10);
    interrupt_request = 8'h01;
    tick(2);
    sequence_8086(1);
    chk("t5_isr", isr, 0);
`ifdef CALL_MODE_8080_EN
    mode_8086 = 0;
    call_address_low = 3'b101;
    interrupt_vector_high = 8'h12;
    priority_rotate = 7;
    interrupt_request = 8'h04;
    tick(2);
    interrupt_acknowledge_n = 0;
    tick();
    chk("c_ack1", {dbo_en, dbo}, {1'b1, 8'hCD});
    interrupt_acknowledge_n = 1;
    tick();
    chk("c_rel1", dbo_en, 0);
    interrupt_acknowledge_n = 0;
    tick();
    chk("c_ack2", {dbo_en, dbo}, {1'b1, 8'hA8});
    interrupt_acknowledge_n = 1;
    tick();
    chk("c_rel2", {dbo_en, eoa}, 0);
    interrupt_acknowledge_n = 0;
    tick();
    chk("c_ack3", {dbo_en, dbo}, {1'b1, 8'h12});
    interrupt_acknowledge_n = 1;
    tick();
    chk("c_eoa", {eoa, ack, dbo_en}, {1'b1, 8'h04, 1'b0});
    m_isr = 8'h04;
    chk("c_isr", isr, m_isr);
    mode_8086 = 1;
    tick();
`endif
    for (int i = 0; i < 40; i++) begin
      priority_rotate = 3'($urandom_range(0, 7));
      interrupt_request = 8'($urandom);
      interrupt_vector_high = 8'($urandom);
      apply_eoi($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00);
      check_idle("rnd");
      if ($urandom_range(0, 1) == 1) sequence_8086($urandom_range(0, 9) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
